// File: rtl/qei_sample_ctrl_if.sv
// Register-file / quadrature-counter side bundle for qei_sample_ctrl.
// master = register file + counter block, slave = qei_sample_ctrl.
interface qei_sample_ctrl_if;
    logic        ENABLE;
    logic [31:0] PERIOD_Set;
    logic [3:0]  HOST_CLEAR_Set;
    logic [31:0] CH0_COUNT;
    logic [31:0] CH1_COUNT;
    logic [31:0] CH2_COUNT;
    logic [31:0] CH3_COUNT;
    logic [31:0] QEI_CLEAR_Out;
    logic [31:0] VEL_CH0_Read;
    logic [31:0] VEL_CH1_Read;
    logic [31:0] VEL_CH2_Read;
    logic [31:0] VEL_CH3_Read;
    logic [31:0] POS_CH0_Read;
    logic [31:0] POS_CH1_Read;
    logic [31:0] POS_CH2_Read;
    logic [31:0] POS_CH3_Read;
    logic [15:0] SAMPLE_SEQ;
    logic        SAMPLE_DONE;
    logic        BUSY;
    logic        OVERRUN;

    modport master (
        output ENABLE, PERIOD_Set, HOST_CLEAR_Set,
        output CH0_COUNT, CH1_COUNT, CH2_COUNT, CH3_COUNT,
        input  QEI_CLEAR_Out,
        input  VEL_CH0_Read, VEL_CH1_Read, VEL_CH2_Read, VEL_CH3_Read,
        input  POS_CH0_Read, POS_CH1_Read, POS_CH2_Read, POS_CH3_Read,
        input  SAMPLE_SEQ, SAMPLE_DONE, BUSY, OVERRUN
    );

    modport slave (
        input  ENABLE, PERIOD_Set, HOST_CLEAR_Set,
        input  CH0_COUNT, CH1_COUNT, CH2_COUNT, CH3_COUNT,
        output QEI_CLEAR_Out,
        output VEL_CH0_Read, VEL_CH1_Read, VEL_CH2_Read, VEL_CH3_Read,
        output POS_CH0_Read, POS_CH1_Read, POS_CH2_Read, POS_CH3_Read,
        output SAMPLE_SEQ, SAMPLE_DONE, BUSY, OVERRUN
    );
endinterface

// File: rtl/qei_sample_ctrl.sv
// qei_sample_ctrl: periodic coherent snapshot of 4 quadrature counts,
// per-channel velocity via one shared subtractor, host clear arbitration.
// Ports: CLK, RST_n (async, active-low), bus (qei_sample_ctrl_if.slave):
//   ENABLE, PERIOD_Set, HOST_CLEAR_Set, CH0..3_COUNT in;
//   QEI_CLEAR_Out, VEL/POS_CH0..3_Read, SAMPLE_SEQ, SAMPLE_DONE,
//   BUSY, OVERRUN out.
// Optional: define QEI_VEL_SAT_EN to clamp velocity to +/-VEL_MAX.
module qei_sample_ctrl #(
    parameter logic [31:0] PERIOD_MIN = 32'd8,
    parameter logic [31:0] VEL_MAX    = 32'h0000_FFFF
) (
    input logic              CLK,
    input logic              RST_n,
    qei_sample_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_DIFF0 = 3'd2;
    localparam logic [2:0] ST_DIFF1 = 3'd3;
    localparam logic [2:0] ST_DIFF2 = 3'd4;
    localparam logic [2:0] ST_DIFF3 = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        tick_pend_q, tick_pend_d;
    logic        ovr_q, ovr_d;
    logic        prime_q, prime_d;
    logic [3:0]  hc_prev_q, hc_prev_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  clr_q, clr_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] snap_q [4];
    logic [31:0] snap_d [4];
    logic [31:0] prev_q [4];
    logic [31:0] prev_d [4];
    logic [31:0] vel_q  [4];
    logic [31:0] vel_d  [4];
    logic [31:0] pos_q  [4];
    logic [31:0] pos_d  [4];

    logic [31:0] cnt [4];
    logic [31:0] p_eff;
    logic        tick_now;
    logic        busy;
    logic [3:0]  rise;
    logic        issue;
    logic [2:0]  idx_w;
    logic [1:0]  idx;
    logic [31:0] diff;
    logic [31:0] d_lim;
    logic [31:0] vel_new;

    assign cnt[0] = bus.CH0_COUNT;
    assign cnt[1] = bus.CH1_COUNT;
    assign cnt[2] = bus.CH2_COUNT;
    assign cnt[3] = bus.CH3_COUNT;

    assign busy  = (state_q != ST_IDLE);
    assign p_eff = (bus.PERIOD_Set < PERIOD_MIN) ? PERIOD_MIN
                                                 : bus.PERIOD_Set;
    // >= rather than == so a period shrunk below the running count
    // wraps at once instead of running to 2^32.
    assign tick_now = bus.ENABLE && (timer_q >= (p_eff - 32'd1));

    assign rise  = bus.HOST_CLEAR_Set & ~hc_prev_q;
    assign issue = (state_q == ST_IDLE) && (pend_q != 4'd0)
                   && (clr_q == 4'd0);

    // Shared subtractor: channel selected by DIFFn state offset.
    assign idx_w = state_q - ST_DIFF0;
    assign idx   = idx_w[1:0];
    assign diff  = snap_q[idx] - prev_q[idx];

`ifdef QEI_VEL_SAT_EN
    localparam logic signed [31:0] VMAX_S = VEL_MAX;
    localparam logic signed [31:0] VMIN_S = -VMAX_S;
    logic signed [31:0] diff_s;
    assign diff_s = $signed(diff);
    always_comb begin
        d_lim = diff;
        if (diff_s > VMAX_S) begin
            d_lim = VMAX_S;
        end else if (diff_s < VMIN_S) begin
            d_lim = VMIN_S;
        end
    end
`else
    assign d_lim = diff;
`endif

    assign vel_new = prime_q ? 32'd0 : d_lim;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tick_pend_d = tick_pend_q;
        ovr_d       = ovr_q;
        prime_d     = prime_q;
        hc_prev_d   = bus.HOST_CLEAR_Set;
        clr_d       = 4'd0;
        seq_d       = seq_q;
        for (int i = 0; i < 4; i++) begin
            snap_d[i] = snap_q[i];
            prev_d[i] = prev_q[i];
            vel_d[i]  = vel_q[i];
            pos_d[i]  = pos_q[i];
        end

        // A coincident rising edge survives the issue clear.
        pend_d = (issue ? 4'd0 : pend_q) | rise;
        if (issue) begin
            clr_d = pend_q;
            for (int i = 0; i < 4; i++) begin
                if (pend_q[i]) begin
                    prev_d[i] = 32'd0;
                end
            end
        end

        if (!bus.ENABLE) begin
            timer_d = 32'd0;
        end else if (tick_now) begin
            timer_d = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
        end

        if (tick_now) begin
            if (tick_pend_q || busy) begin
                ovr_d = 1'b1;
            end else begin
                tick_pend_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick_pend_q && (pend_q == 4'd0)
                    && (clr_q == 4'd0)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                for (int i = 0; i < 4; i++) begin
                    snap_d[i] = cnt[i];
                    pos_d[i]  = cnt[i];
                end
                tick_pend_d = 1'b0;
                state_d     = ST_DIFF0;
            end
            ST_DIFF0, ST_DIFF1, ST_DIFF2, ST_DIFF3: begin
                vel_d[idx]  = vel_new;
                prev_d[idx] = snap_q[idx];
                if (state_q == ST_DIFF3) begin
                    // Count lands with the SAMPLE_DONE pulse.
                    seq_d   = seq_q + 16'd1;
                    state_d = ST_DONE;
                end else begin
                    state_d = state_q + 3'd1;
                end
            end
            ST_DONE: begin
                prime_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!bus.ENABLE) begin
            prime_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= 32'd0;
            tick_pend_q <= 1'b0;
            ovr_q       <= 1'b0;
            prime_q     <= 1'b1;
            hc_prev_q   <= 4'd0;
            pend_q      <= 4'd0;
            clr_q       <= 4'd0;
            seq_q       <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= 32'd0;
                prev_q[i] <= 32'd0;
                vel_q[i]  <= 32'd0;
                pos_q[i]  <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tick_pend_q <= tick_pend_d;
            ovr_q       <= ovr_d;
            prime_q     <= prime_d;
            hc_prev_q   <= hc_prev_d;
            pend_q      <= pend_d;
            clr_q       <= clr_d;
            seq_q       <= seq_d;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= snap_d[i];
                prev_q[i] <= prev_d[i];
                vel_q[i]  <= vel_d[i];
                pos_q[i]  <= pos_d[i];
            end
        end
    end

    assign bus.QEI_CLEAR_Out = {28'd0, clr_q};
    assign bus.VEL_CH0_Read  = vel_q[0];
    assign bus.VEL_CH1_Read  = vel_q[1];
    assign bus.VEL_CH2_Read  = vel_q[2];
    assign bus.VEL_CH3_Read  = vel_q[3];
    assign bus.POS_CH0_Read  = pos_q[0];
    assign bus.POS_CH1_Read  = pos_q[1];
    assign bus.POS_CH2_Read  = pos_q[2];
    assign bus.POS_CH3_Read  = pos_q[3];
    assign bus.SAMPLE_SEQ    = seq_q;
    assign bus.SAMPLE_DONE   = (state_q == ST_DONE);
    assign bus.BUSY          = busy;
    assign bus.OVERRUN       = ovr_q;

endmodule
